memory_port_arbiter: RTL

// - Shares one memory target port (local SRAM or WB bridge) between the core instruction and data requesters.
// - Sits between the core fetch/load-store units and a single target port.
// - Sequences one transaction at a time and holds the grant until the target completes.
// - Data requests have priority; a starvation counter guarantees instruction fetch progress.

---
 rtl/memory_arbiter_pkg.sv | 18 +
 rtl/memory_port_arbiter_if.sv | 46 ++++
 rtl/memory_arbiter_select.sv | 48 ++++
 rtl/memory_port_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter slice.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE_INST,
    ACTIVE_DATA
  } arbState_t;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_INST,
    OWNER_DATA
  } owner_t;

  localparam logic [31:0] DEFAULT_READ_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Bundle of requester (instruction, data) and target port signals around the arbiter.
interface memory_port_arbiter_if #(
  parameter int ADDRESS_WIDTH = 24
);

  logic                     instEnable;
  logic [ADDRESS_WIDTH-1:0] instAddress;
  logic [31:0]              instDataRead;
  logic                     instBusy;

  logic                     dataEnable;
  logic                     dataWriteEnable;
  logic [ADDRESS_WIDTH-1:0] dataAddress;
  logic [3:0]               dataByteSelect;
  logic [31:0]              dataDataWrite;
  logic [31:0]              dataDataRead;
  logic                     dataBusy;

  logic                     targetEnable;
  logic                     targetWriteEnable;
  logic [ADDRESS_WIDTH-1:0] targetAddress;
  logic [3:0]               targetByteSelect;
  logic [31:0]              targetDataWrite;
  logic [31:0]              targetDataRead;
  logic                     targetBusy;

  // Environment side: core requesters plus the memory target.
  modport master (
    output instEnable, instAddress,
    input  instDataRead, instBusy,
    output dataEnable, dataWriteEnable, dataAddress, dataByteSelect, dataDataWrite,
    input  dataDataRead, dataBusy,
    input  targetEnable, targetWriteEnable, targetAddress, targetByteSelect, targetDataWrite,
    output targetDataRead, targetBusy
  );

  modport slave (
    input  instEnable, instAddress,
    output instDataRead, instBusy,
    input  dataEnable, dataWriteEnable, dataAddress, dataByteSelect, dataDataWrite,
    output dataDataRead, dataBusy,
    output targetEnable, targetWriteEnable, targetAddress, targetByteSelect, targetDataWrite,
    input  targetDataRead, targetBusy
  );

endinterface

// File: rtl/memory_arbiter_select.sv
// Winner selection between instruction and data requesters with a starvation counter
// that hands a contested grant to the instruction side after STARVE_LIMIT data wins.
module memory_arbiter_select
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   grant,
  input  logic   instEnable,
  input  logic   dataEnable,
  output owner_t winner
);

  localparam int COUNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(STARVE_LIMIT);

  logic [COUNT_WIDTH-1:0] starveCount;
  logic                   contested;

  assign contested = instEnable & dataEnable;

  always_comb begin
    winner = OWNER_NONE;
    if (contested) begin
      winner = (starveCount == LIMIT) ? OWNER_INST : OWNER_DATA;
    end else if (dataEnable) begin
      winner = OWNER_DATA;
    end else if (instEnable) begin
      winner = OWNER_INST;
    end
  end

  // Only grants issued from IDLE move the counter; no-request IDLE cycles leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starveCount <= '0;
    end else if (grant) begin
      if (winner == OWNER_INST) begin
        starveCount <= '0;
      end else if (contested && (starveCount != LIMIT)) begin
        starveCount <= starveCount + 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one memory target port between instruction fetch and data load/store,
// one transaction at a time, holding the grant until the target completes.
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 24,
  parameter int STARVE_LIMIT  = 4
) (
  input logic                  clk,
  input logic                  rst,
  memory_port_arbiter_if.slave bus
);

  arbState_t state, nextState;
  owner_t    owner, nextOwner, winner;
  logic      grant;
  logic      ownerEnable;
  logic      driveInst, driveData;
  logic      instDone, dataDone;

  assign grant = (state == IDLE);

  memory_arbiter_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant),
    .instEnable(bus.instEnable),
    .dataEnable(bus.dataEnable),
    .winner    (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= OWNER_NONE;
    end else begin
      state <= nextState;
      owner <= nextOwner;
    end
  end

  // Gating on rst keeps the target quiet for the whole reset window, not just until the state clears.
  always_comb begin
    nextState   = state;
    nextOwner   = owner;
    ownerEnable = 1'b0;
    driveInst   = 1'b0;
    driveData   = 1'b0;
    instDone    = 1'b0;
    dataDone    = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE: begin
          if (winner == OWNER_INST) begin
            driveInst = 1'b1;
            nextState = ACTIVE_INST;
            nextOwner = OWNER_INST;
          end else if (winner == OWNER_DATA) begin
            driveData = 1'b1;
            nextState = ACTIVE_DATA;
            nextOwner = OWNER_DATA;
          end
        end
        ACTIVE_INST, ACTIVE_DATA: begin
          ownerEnable = (owner == OWNER_INST) ? bus.instEnable : bus.dataEnable;
          if (!ownerEnable) begin
            nextState = IDLE;
            nextOwner = OWNER_NONE;
          end else begin
            driveInst = (owner == OWNER_INST);
            driveData = (owner == OWNER_DATA);
            if (!bus.targetBusy) begin
              instDone  = driveInst;
              dataDone  = driveData;
              nextState = IDLE;
              nextOwner = OWNER_NONE;
            end
          end
        end
        default: begin
          nextState = IDLE;
          nextOwner = OWNER_NONE;
        end
      endcase
    end
  end

  assign bus.targetEnable      = driveInst | driveData;
  assign bus.targetWriteEnable = driveData & bus.dataWriteEnable;
  assign bus.targetAddress     = driveData ? bus.dataAddress    : (driveInst ? bus.instAddress : '0);
  assign bus.targetByteSelect  = driveData ? bus.dataByteSelect : (driveInst ? 4'b1111 : 4'b0000);
  assign bus.targetDataWrite   = driveData ? bus.dataDataWrite  : '0;

  assign bus.instBusy     = ~instDone;
  assign bus.instDataRead = instDone ? bus.targetDataRead : DEFAULT_READ_DATA;
  assign bus.dataBusy     = ~dataDone;
  assign bus.dataDataRead = dataDone ? bus.targetDataRead : DEFAULT_READ_DATA;

endmodule
